seq_divider_nbit: RTL and testbench

Sequential N-bit unsigned restoring divider: the iterative inverse of the arithmetic blocks in this chapter. It produces a quotient and remainder one bit per clock. Each step uses the existing N-bit ripple-carry adder/subtractor in subtract mode. It sits beside the combinational arithmetic units as the first multi-cycle datapath block, with a start/done handshake for an upstream controller.

---
 rtl/seq_div_pkg.sv | 16 +
 rtl/seq_divider_nbit_rcas.sv | 29 ++
 rtl/seq_divider_nbit.sv | 188 ++++++++++++++++++
 tb/tb_seq_divider_nbit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_div_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Iteration counter width: must hold the value n (counts n down to 0)
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_divider_nbit_rcas.sv
// N-bit ripple-carry adder/subtractor. add_sub=1 computes a - b as
// a + ~b + 1; c_out=1 then means no borrow occurred.
module RCAS_Nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         add_sub,
  output logic [N-1:0] sum,
  output logic         c_out
);

  logic [N:0]   carry;
  logic [N-1:0] b_x;

  // Ripple the carry through one full adder per bit
  always_comb begin
    b_x      = b ^ {N{add_sub}};
    carry    = '0;
    sum      = '0;
    carry[0] = add_sub;
    for (int i = 0; i < N; i++) begin
      sum[i]       = a[i] ^ b_x[i] ^ carry[i];
      carry[i + 1] = (a[i] & b_x[i]) | (carry[i] & (a[i] ^ b_x[i]));
    end
    c_out = carry[N];
  end

endmodule

// File: rtl/seq_divider_nbit.sv
// Sequential N-bit unsigned restoring divider, one quotient bit per clock,
// with a start/busy/done handshake.
// Optional feature macro: SEQ_DIV_DIVZERO_EN (zero-divisor shortcut + flag).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; results from the last operation held
// RUN   | one restoring iteration per cycle, counter N down to 0
// DONE  | done pulse; start here re-enters RUN with no idle cycle
module seq_divider_nbit
  import seq_div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = cnt_width(N);

  div_state_e state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  rem_q, rem_d;       // partial remainder R
  logic [N-1:0]  quo_q, quo_d;       // Q: unconsumed dividend bits + quotient bits
  logic [N-1:0]  dsr_q, dsr_d;       // latched divisor
  logic [N-1:0]  quotient_q, quotient_d;
  logic [N-1:0]  remainder_q, remainder_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

`ifdef SEQ_DIV_DIVZERO_EN
  logic          dz_q, dz_d;         // div_by_zero result flag
  logic          dzp_q, dzp_d;       // zero divisor seen at accept
`endif

  logic          accept;
  logic          last_iter;
  logic          finish;
  logic [N:0]    rem_sh;
  logic [N:0]    trial;
  logic          no_borrow;
  logic          trial_msb_unused;
  logic [N-1:0]  rem_step;
  logic [N-1:0]  quo_step;

  // Trial subtraction R_shifted - divisor at N+1 bits
  RCAS_Nbit #(.N(N + 1)) u_rcas (
    .a       (rem_sh),
    .b       ({1'b0, dsr_q}),
    .add_sub (1'b1),
    .sum     (trial),
    .c_out   (no_borrow)
  );

  // The remainder never exceeds N bits, so the trial MSB is never needed
  assign trial_msb_unused = trial[N];

  // One restoring step: shift {R,Q}, keep trial if no borrow, else restore
  always_comb begin
    rem_sh   = {rem_q, quo_q[N-1]};
    rem_step = no_borrow ? trial[N-1:0] : rem_sh[N-1:0];
    quo_step = {quo_q[N-2:0], no_borrow};
  end

  // Handshake and iteration-end decode
  always_comb begin
    accept    = start && ((state_q == IDLE) || (state_q == DONE));
    last_iter = (cnt_q == CW'(1));
`ifdef SEQ_DIV_DIVZERO_EN
    finish    = last_iter || dzp_q;
`else
    finish    = last_iter;
`endif
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (finish) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, registered from the next state so they leave on flops
  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // Datapath next-state: operand latch, iteration, result capture
  always_comb begin
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsr_d       = dsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef SEQ_DIV_DIVZERO_EN
    dz_d        = dz_q;
    dzp_d       = dzp_q;
`endif
    if (accept) begin
      dsr_d = divisor;
      quo_d = dividend;
      rem_d = '0;
      cnt_d = CW'(N);
`ifdef SEQ_DIV_DIVZERO_EN
      dzp_d = (divisor == '0);
`endif
    end else if (state_q == RUN) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q - CW'(1);
      if (last_iter) begin
        quotient_d  = quo_step;
        remainder_d = rem_step;
`ifdef SEQ_DIV_DIVZERO_EN
        dz_d        = 1'b0;
`endif
      end
`ifdef SEQ_DIV_DIVZERO_EN
      // Zero divisor: Q still holds the untouched dividend
      if (dzp_q) begin
        quotient_d  = '1;
        remainder_d = quo_q;
        dz_d        = 1'b1;
        dzp_d       = 1'b0;
      end
`endif
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SEQ_DIV_DIVZERO_EN
      dz_q        <= 1'b0;
      dzp_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dsr_q       <= dsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SEQ_DIV_DIVZERO_EN
      dz_q        <= dz_d;
      dzp_q       <= dzp_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef SEQ_DIV_DIVZERO_EN
  assign div_by_zero = dz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider_nbit.sv
// Self-checking bench for seq_divider_nbit (N=4): vector table, hand-written
// corner sequences and a shuffled sweep of all operand pairs.
module tb_seq_divider_nbit;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
  } vec_t;

  vec_t tbl[8];
  int   order[256];

  always #5 clk = ~clk;

  seq_divider_nbit #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [N-1:0] b);
`ifdef SEQ_DIV_DIVZERO_EN
    return (b == 0) ? 1 : N;
`else
    return N;
`endif
  endfunction

  function automatic logic exp_dz(input logic [N-1:0] b);
`ifdef SEQ_DIV_DIVZERO_EN
    return (b == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_q"}, quotient, 0);
    chk({nm, "_r"}, remainder, 0);
    chk({nm, "_dz"}, div_by_zero, 0);
  endtask

  // Present operands with start; returns 1ns after the accepting edge
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called 1ns after the accepting edge; measures latency and busy length
  task automatic wait_done(input string nm, input logic [N-1:0] b,
                           input logic [N-1:0] eq, input logic [N-1:0] er);
    int cyc;
    int bcnt;
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
    while (!done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy) bcnt++;
    end
    chk({nm, "_lat"}, cyc, exp_lat(b));
    chk({nm, "_q"}, quotient, eq);
    chk({nm, "_r"}, remainder, er);
    chk({nm, "_dz"}, div_by_zero, exp_dz(b));
    if (exp_lat(b) == N) chk({nm, "_busy_len"}, bcnt, N);
  endtask

  initial begin
    int cyc;
    logic [N-1:0] a, b, eq, er;

    tbl[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1};
    tbl[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0};
    tbl[2] = '{a: 4'd2,  b: 4'd7,  q: 4'd0,  r: 4'd2};
    tbl[3] = '{a: 4'd9,  b: 4'd0,  q: 4'd15, r: 4'd9};
    tbl[4] = '{a: 4'd10, b: 4'd3,  q: 4'd3,  r: 4'd1};
    tbl[5] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0};
    tbl[6] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0};
    tbl[7] = '{a: 4'd7,  b: 4'd8,  q: 4'd0,  r: 4'd7};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors, each started from IDLE
    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].a, tbl[i].b);
      wait_done($sformatf("tbl%0d", i), tbl[i].b, tbl[i].q, tbl[i].r);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_done_pulse", i), done, 0);
      chk($sformatf("tbl%0d_idle_busy", i), busy, 0);
    end

    // Back-to-back: start held during done re-enters RUN with no gap
    issue(4'd15, 4'd1);
    wait_done("b2b_first", 4'd1, 4'd15, 4'd0);
    dividend = 4'd2;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy_nogap", busy, 1);
    chk("b2b_done_low", done, 0);
    wait_done("b2b_second", 4'd7, 4'd0, 4'd2);
    @(posedge clk);
    #1;

    // start pulsed mid-RUN is ignored
    issue(4'd14, 4'd5);
    @(negedge clk);
    dividend = 4'd6;
    divisor  = 4'd4;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("ignore_lat", cyc, N);
    chk("ignore_q", quotient, 2);
    chk("ignore_r", remainder, 4);
    @(posedge clk);
    #1;

    // Asynchronous reset in the second RUN cycle
    issue(4'd12, 4'd5);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    issue(4'd10, 4'd3);
    wait_done("after_rst", 4'd3, 4'd3, 4'd1);

    // Shuffled sweep of every operand pair against plain arithmetic
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i, 0));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      a  = N'(order[i] >> N);
      b  = N'(order[i]);
      eq = (b == 0) ? {N{1'b1}} : N'(int'(a) / int'(b));
      er = (b == 0) ? a : N'(int'(a) % int'(b));
      issue(a, b);
      wait_done($sformatf("sweep_%0d_%0d", a, b), b, eq, er);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
